// File: rtl/stream_requant_if.sv
// rtl/stream_requant_if.sv - AXI-stream style bundle (tdata/tvalid/tready/tlast) used by stream_requant.
interface axi_stream_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport axi_in  (input  tdata, input  tvalid, input  tlast, output tready);
    modport axi_out (output tdata, output tvalid, output tlast, input  tready);
endinterface

// File: rtl/stream_requant.sv
// rtl/stream_requant.sv - 3-stage requantiser: (x*MULT + round) >>> SHIFT, saturate to D_W, counter-framed tlast.
// Optional macro STREAM_REQUANT_SAT_CNT_EN adds the per-matrix saturation count output sat_cnt.
module stream_requant #(
    parameter int IN_W         = 32,
    parameter int D_W          = 8,
    parameter int MULT_W       = 16,
    parameter int SHIFT_W      = 6,
    parameter int MATRIXSIZE_W = 24,
    parameter int OUT_BUS_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_stream_if.axi_in            in_acc,
    axi_stream_if.axi_out           out_q,
    input  logic [MULT_W-1:0]       MULT,
    input  logic [SHIFT_W-1:0]      SHIFT,
    input  logic [MATRIXSIZE_W-1:0] DEPTH,
    output logic                    err_last
`ifdef STREAM_REQUANT_SAT_CNT_EN
    ,
    output logic [MATRIXSIZE_W-1:0] sat_cnt
`endif
);
    localparam int PW = IN_W + MULT_W + 1;
    localparam int AW = PW + 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (D_W - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 << (D_W - 1)));

    logic w_en;
    logic w_hs;
    logic w_first;
    logic w_gl;
    logic [MULT_W-1:0]  w_mult;
    logic [SHIFT_W-1:0] w_shift;

    logic [MATRIXSIZE_W-1:0] r_cnt;
    logic [MULT_W-1:0]       r_mult_sh;
    logic [SHIFT_W-1:0]      r_shift_sh;
    logic                    r_err_last;

    logic                     r_s1_valid;
    logic signed [IN_W-1:0]   r_s1_x;
    logic [MULT_W-1:0]        r_s1_mult;
    logic [SHIFT_W-1:0]       r_s1_shift;
    logic                     r_s1_last;

    logic                     r_s2_valid;
    logic signed [PW-1:0]     r_s2_prod;
    logic [SHIFT_W-1:0]       r_s2_shift;
    logic                     r_s2_last;

    logic                     r_s3_valid;
    logic signed [D_W-1:0]    r_s3_data;
    logic                     r_s3_last;

    logic signed [PW-1:0]     w_x_ext;
    logic signed [PW-1:0]     w_m_ext;
    logic signed [PW-1:0]     w_prod;
    int                       w_sh;
    logic signed [AW-1:0]     w_round;
    logic signed [AW-1:0]     w_sum;
    logic signed [AW-1:0]     w_res;
    logic signed [D_W-1:0]    w_sat;

    assign w_en          = !r_s3_valid || out_q.tready;
    assign in_acc.tready = w_en;
    assign w_hs          = in_acc.tvalid && w_en;

    assign w_first = (r_cnt == '0);
    assign w_gl    = (r_cnt == DEPTH - MATRIXSIZE_W'(1)) || (DEPTH <= MATRIXSIZE_W'(1));
    // First element of a matrix uses the live scale; the rest use the value captured with it.
    assign w_mult  = w_first ? MULT  : r_mult_sh;
    assign w_shift = w_first ? SHIFT : r_shift_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_mult_sh  <= '0;
            r_shift_sh <= '0;
            r_err_last <= 1'b0;
        end else if (w_hs) begin
            r_cnt <= w_gl ? '0 : r_cnt + 1'b1;
            if (w_first) begin
                r_mult_sh  <= MULT;
                r_shift_sh <= SHIFT;
            end
            if (in_acc.tlast != w_gl) begin
                r_err_last <= 1'b1;
            end
        end
    end

    assign err_last = r_err_last;

    assign w_x_ext = PW'(r_s1_x);
    assign w_m_ext = PW'({1'b0, r_s1_mult});
    assign w_prod  = w_x_ext * w_m_ext;

    // Shifts past PW all give 0 after rounding, so clamping keeps the round constant in range.
    always_comb begin
        w_sh    = (int'(r_s2_shift) > PW) ? PW : int'(r_s2_shift);
        w_round = (w_sh == 0) ? '0 : (AW'(1) << (w_sh - 1));
        w_sum   = AW'(r_s2_prod) + w_round;
        w_res   = w_sum >>> w_sh;
        if (w_res > SAT_MAX) begin
            w_sat = {1'b0, {(D_W-1){1'b1}}};
        end else if (w_res < SAT_MIN) begin
            w_sat = {1'b1, {(D_W-1){1'b0}}};
        end else begin
            w_sat = D_W'(w_res);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_mult  <= '0;
            r_s1_shift <= '0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_shift <= '0;
            r_s2_last  <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_data  <= '0;
            r_s3_last  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_acc.tvalid;
            r_s1_x     <= in_acc.tdata[IN_W-1:0];
            r_s1_mult  <= w_mult;
            r_s1_shift <= w_shift;
            r_s1_last  <= in_acc.tvalid && w_gl;
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_prod;
            r_s2_shift <= r_s1_shift;
            r_s2_last  <= r_s1_valid && r_s1_last;
            r_s3_valid <= r_s2_valid;
            r_s3_data  <= w_sat;
            r_s3_last  <= r_s2_valid && r_s2_last;
        end
    end

    assign out_q.tvalid = r_s3_valid;
    assign out_q.tlast  = r_s3_last;
    assign out_q.tdata  = {{(OUT_BUS_W-D_W){r_s3_data[D_W-1]}}, r_s3_data};

`ifdef STREAM_REQUANT_SAT_CNT_EN
    logic                    w_clamp;
    logic                    r_s3_sat;
    logic [MATRIXSIZE_W-1:0] r_sat_acc;
    logic [MATRIXSIZE_W-1:0] r_sat_cnt;
    logic [MATRIXSIZE_W-1:0] w_sat_next;

    assign w_clamp    = (w_res > SAT_MAX) || (w_res < SAT_MIN);
    assign w_sat_next = r_sat_acc + MATRIXSIZE_W'(r_s3_sat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_sat  <= 1'b0;
            r_sat_acc <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (w_en) begin
                r_s3_sat <= r_s2_valid && w_clamp;
            end
            if (r_s3_valid && out_q.tready) begin
                if (r_s3_last) begin
                    r_sat_cnt <= w_sat_next;
                    r_sat_acc <= '0;
                end else begin
                    r_sat_acc <= w_sat_next;
                end
            end
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif
endmodule

// File: tb/tb_stream_requant.sv
// tb/tb_stream_requant.sv - scoreboard bench for stream_requant with an arithmetic reference model.
module tb_stream_requant;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mult;
    logic [5:0]  shift;
    logic [23:0] depth;
    logic        err_last;
`ifdef STREAM_REQUANT_SAT_CNT_EN
    logic [23:0] sat_cnt;
`endif

    axi_stream_if #(.DATA_W(32)) in_if ();
    axi_stream_if #(.DATA_W(32)) out_if ();

    stream_requant #(
        .IN_W(32), .D_W(8), .MULT_W(16), .SHIFT_W(6), .MATRIXSIZE_W(24), .OUT_BUS_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_acc(in_if),
        .out_q(out_if),
        .MULT(mult),
        .SHIFT(shift),
        .DEPTH(depth),
        .err_last(err_last)
`ifdef STREAM_REQUANT_SAT_CNT_EN
        ,
        .sat_cnt(sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] data;
        logic               last;
        int                 hs_cyc;
        bit                 chk_lat;
        int                 sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    int          m_cnt = 0;
    logic [15:0] m_mult = '0;
    logic [5:0]  m_shift = '0;
    bit          m_err = 0;
    int          m_sat_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Exact math: round half up, floor shift, clamp to int8.
    function automatic longint requant(input longint x, input longint m, input int s, output bit sat);
        longint p;
        longint r;
        p = x * m;
        if (s == 0) r = p;
        else        r = (p + (longint'(1) <<< (s - 1))) >>> s;
        sat = 1'b0;
        if (r > 127) begin r = 127; sat = 1'b1; end
        else if (r < -128) begin r = -128; sat = 1'b1; end
        return r;
    endfunction

    task automatic model_hs(input int x, input bit last);
        exp_t e;
        bit   gl;
        bit   sat;
        int   d;
        d  = int'(depth);
        gl = (m_cnt == d - 1) || (d <= 1);
        if (m_cnt == 0) begin
            m_mult  = mult;
            m_shift = shift;
        end
        if (last != gl) m_err = 1;
        e.data    = 32'(requant(longint'(x), longint'(m_mult), int'(m_shift), sat));
        e.last    = gl;
        e.hs_cyc  = cyc + 1;
        e.chk_lat = (rdy_mode == 0);
        m_sat_run += int'(sat);
        e.sat     = m_sat_run;
        if (gl) m_sat_run = 0;
        m_cnt = gl ? 0 : m_cnt + 1;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_err = 0; m_sat_run = 0;
        exp_q.delete();
    endtask

    // Called at a negedge; returns at the negedge following the handshake.
    task automatic send(input int x, input bit last);
        int guard;
        guard = 0;
        in_if.tvalid = 1'b1;
        in_if.tdata  = x;
        in_if.tlast  = last;
        #1;
        while (!in_if.tready) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL in_tready_timeout: got tready=%0b required 1 within 200 cycles", in_if.tready);
                in_if.tvalid = 1'b0;
                return;
            end
        end
        model_hs(x, last);
        @(negedge clk);
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        checks++;
        if (err_last !== m_err) begin
            errors++;
            $display("FAIL err_last_after_hs: got %0b required %0b", err_last, m_err);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int pat;
        pat = 0;
        out_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_if.tready = 1'b1;
                1:       begin out_if.tready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
                default: out_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        bit          prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;
        bit          sat_pend;
        int          sat_exp;
        exp_t        e;
        prev_stall = 0; prev_d = '0; prev_l = 0; sat_pend = 0; sat_exp = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 0;
                sat_pend   = 0;
                continue;
            end
`ifdef STREAM_REQUANT_SAT_CNT_EN
            if (sat_pend) begin
                checks++;
                if (sat_cnt !== 24'(sat_exp)) begin
                    errors++;
                    $display("FAIL sat_cnt: got %0d required %0d", sat_cnt, sat_exp);
                end
            end
`endif
            sat_pend = 0;
            if (prev_stall) begin
                checks++;
                if (out_if.tvalid !== 1'b1 || out_if.tdata !== prev_d || out_if.tlast !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0d l=%0b required v=1 d=%0d l=%0b",
                             out_if.tvalid, $signed(out_if.tdata), out_if.tlast, $signed(prev_d), prev_l);
                end
            end
            if (out_if.tvalid === 1'b1 && out_if.tready === 1'b0) begin
                checks++;
                if (in_if.tready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_tready_stall: got %0b required 0", in_if.tready);
                end
            end
            if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%0d required no beat", $signed(out_if.tdata));
                end else begin
                    e = exp_q.pop_front();
                    if (out_if.tdata !== e.data || out_if.tlast !== e.last) begin
                        errors++;
                        $display("FAIL out_beat: got d=%0d l=%0b required d=%0d l=%0b",
                                 $signed(out_if.tdata), out_if.tlast, e.data, e.last);
                    end
                    if (e.chk_lat) begin
                        checks++;
                        if (cyc != e.hs_cyc + 2) begin
                            errors++;
                            $display("FAIL latency: got cycle %0d required %0d", cyc, e.hs_cyc + 2);
                        end
                    end
                    if (e.last) begin
                        sat_pend = 1;
                        sat_exp  = e.sat;
                    end
                end
            end
            prev_stall = (out_if.tvalid === 1'b1) && (out_if.tready === 1'b0);
            prev_d     = out_if.tdata;
            prev_l     = out_if.tlast;
        end
    end

    initial begin
        int vals1[4];
        int n;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tlast  = 1'b0;
        mult = 16'd1; shift = 6'd0; depth = 24'd4;
        repeat (3) @(negedge clk);
        checks++;
        if (out_if.tvalid !== 1'b0 || out_if.tlast !== 1'b0 || out_if.tdata !== 32'd0 || err_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b l=%0b d=%0d err=%0b required 0 0 0 0",
                     out_if.tvalid, out_if.tlast, out_if.tdata, err_last);
        end
        rst = 1'b0;
        @(negedge clk);

        // Basic saturation with unit scale
        vals1 = '{5, 300, -300, -128};
        for (int i = 0; i < 4; i++) send(vals1[i], i == 3);
        drain();

        // Rounding: 3*10/4 -> 8, -30/4 -> -7, then 3/2 -> 2
        mult = 16'd3; shift = 6'd2; depth = 24'd2;
        send(10, 0);
        send(-10, 1);
        mult = 16'd1; shift = 6'd1;
        send(3, 0);
        send(0, 1);
        drain();

        // Backpressure 1,0,0,1
        rdy_mode = 1;
        mult = 16'd7; shift = 6'd3; depth = 24'd16;
        for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 600)) - 300, i == 15);
        drain();
        rdy_mode = 0;
        repeat (4) @(negedge clk);

        // Scale captured on the first element only
        mult = 16'd2; shift = 6'd0; depth = 24'd3;
        send(20, 0);
        mult = 16'd5;
        send(21, 0);
        send(-22, 1);
        send(20, 0);
        send(-9, 0);
        send(3, 1);
        drain();

        // Early tlast on the 3rd element
        mult = 16'd1; shift = 6'd0; depth = 24'd4;
        send(1, 0);
        send(2, 0);
        send(3, 1);
        send(4, 0);
        drain();

        // Reset with two elements in flight
        send(11, 0);
        send(12, 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_if.tvalid !== 1'b0 || err_last !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got v=%0b err=%0b required 0 0", out_if.tvalid, err_last);
        end
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) send(i * 40, i == 3);
        drain();

        // Randomized matrices under random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 30; k++) begin
            depth = 24'($urandom_range(0, 6));
            mult  = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
            shift = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 20)) : 6'($urandom_range(0, 63));
            n = (depth <= 1) ? 1 : int'(depth);
            for (int j = 0; j < n; j++) begin
                send(($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000, j == n - 1);
                mult  = 16'($urandom);
                shift = 6'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();
        checks++;
        if (err_last !== 1'b0) begin
            errors++;
            $display("FAIL err_last_final: got %0b required 0", err_last);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
